// File: rtl/mul_add_collect_pkg.sv
// Shared defaults and the record type used by the mul-add result collector.
package mul_add_collect_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ACC_W      = 48;
  localparam int unsigned DEF_GROUP      = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = $clog2(DEF_GROUP + 1);
  localparam int unsigned DEF_LVL_W      = $clog2(DEF_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DEF_ACC_W-1:0] sum;
    logic [DEF_CNT_W-1:0] count;
    logic                 partial;
  } collect_rec_t;

endpackage

// File: rtl/mul_add_collect_fifo.sv
// First-word fall-through record FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module mul_add_collect_fifo import mul_add_collect_pkg::*; #(
  parameter type         rec_t = collect_rec_t,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  rec_t             wdata_i,
  input  logic             pop_i,
  output rec_t             rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  rec_t             mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (level_q == '0);
    full_o   = (level_q == LVL_W'(DEPTH));
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    level_o  = level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mul_add_result_collector.sv
// Sums groups of GROUP mul-add results (or fewer on flush) and queues the closed
// records; never stalls the input, drops records and flags overflow when full.
module mul_add_result_collector import mul_add_collect_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned GROUP      = DEF_GROUP,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned CNT_W     = $clog2(GROUP + 1),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_partial,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);

  // Same layout as collect_rec_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             partial;
  } rec_t;

  logic [ACC_W-1:0] acc_q, acc_d, acc_nx, data_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, empty;
  rec_t             push_rec, head_rec;

  always_comb begin
    data_ext               = '0;
    data_ext[DATA_W-1:0]   = in_data;
    acc_nx                 = acc_q;
    cnt_nx                 = cnt_q;
    if (in_valid) begin
      acc_nx = acc_q + data_ext;
      cnt_nx = cnt_q + CNT_W'(1);
    end
    // A flush landing on the GROUP-th beat folds into the same single record.
    push = (in_valid && (cnt_nx == CNT_W'(GROUP))) ||
           (flush && ((cnt_q != '0) || in_valid));
    push_rec.sum     = acc_nx;
    push_rec.count   = cnt_nx;
    push_rec.partial = (cnt_nx != CNT_W'(GROUP));
    acc_d            = push ? '0 : acc_nx;
    cnt_d            = push ? '0 : cnt_nx;
    pop              = ~empty & out_ready;
    ovf_d            = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  mul_add_collect_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    out_valid   = ~empty;
    out_sum     = head_rec.sum;
    out_count   = head_rec.count;
    out_partial = head_rec.partial;
    overflow    = ovf_q;
  end

endmodule
